// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Samples the synchronised line at mid-bit
// using a BAUD_DIV cycle bit timer and emits one-cycle valid/error strobes.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 87
) (
    input  logic       fpga_clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [1:0]    sync_q;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;
    logic          cnt_clr;
    logic          shift_en;
    logic          load_data;
    logic          set_err;

    assign rxs = sync_q[1];

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], RxD};
        end
    end

    // State register.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-cycle datapath controls.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        load_data  = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    next_state = S_START;
                    cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_clr    = 1'b1;
                    next_state = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        next_state = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr = 1'b1;
                    if (rxs) begin
                        load_data  = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        set_err    = 1'b1;
                        next_state = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Bit timer, bit index and LSB-first shift register.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (state == S_START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift_q <= {rxs, shift_q[7:1]};
            end
        end
    end

    // Registered outputs: strobes follow the stop sample by one cycle.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_valid  <= load_data;
            frame_err <= set_err;
            rx_busy   <= (next_state != S_IDLE);
            if (load_data) begin
                rx_data <= shift_q;
            end
        end
    end

endmodule
